// File: rtl/debounce_fsm.sv
// Debounces a raw switch into a registered level plus one-cycle rise/fall pulses.
// Define DEBOUNCE_SYNC_EN to put a 2-flop synchronizer in front of the FSM.
module debounce_fsm #(
  parameter int CNT_W      = 20,
  parameter int STABLE_CNT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic db_rise,
  output logic db_fall,
  output logic busy
);

  localparam logic [1:0] ZERO  = 2'b00;
  localparam logic [1:0] WAIT1 = 2'b01;
  localparam logic [1:0] ONE   = 2'b11;
  localparam logic [1:0] WAIT0 = 2'b10;

  // First window sample is taken on entry, so the counter covers the rest.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STABLE_CNT - 1);

  logic             sw_s;
  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             rise_nx;
  logic             fall_nx;

`ifdef DEBOUNCE_SYNC_EN
  logic sync1;
  logic sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  assign sw_s = sync2;
`else
  assign sw_s = sw;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rise_nx  = 1'b0;
    fall_nx  = 1'b0;
    case (state)
      ZERO: begin
        if (sw_s) begin
          state_nx = WAIT1;
          cnt_nx   = RELOAD;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_nx = ZERO;
        end else if (cnt == '0) begin
          state_nx = ONE;
          rise_nx  = 1'b1;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_nx = WAIT0;
          cnt_nx   = RELOAD;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_nx = ONE;
        end else if (cnt == '0) begin
          state_nx = ZERO;
          fall_nx  = 1'b1;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = ZERO;
    endcase
  end

  // Outputs decode the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ZERO;
      cnt      <= '0;
      db_level <= 1'b0;
      db_rise  <= 1'b0;
      db_fall  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      db_level <= (state_nx == ONE) || (state_nx == WAIT0);
      db_rise  <= rise_nx;
      db_fall  <= fall_nx;
      busy     <= (state_nx == WAIT1) || (state_nx == WAIT0);
    end
  end

endmodule

// File: doc/debounce_fsm.md
Name: debounce_fsm

Overview:
- Conditions a raw mechanical switch/button input into a clean, glitch-free level.
- Sits directly upstream of the edge detector stage: db_level feeds its level input.
- Also provides its own registered rise/fall pulses for consumers that need no separate edge stage.
- Four-state FSM plus a down-counter qualifies each transition; a change is accepted only after the input holds stable for STABLE_CNT+1 consecutive samples.

Parameters:
- CNT_W, 20, width of the stability down-counter.
- STABLE_CNT, 1000000, stability window in clk cycles (10 ms at 100 MHz). Must satisfy 1 <= STABLE_CNT <= 2^CNT_W - 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- sw  input  1  raw, noisy switch input; may be asynchronous to clk.
- db_level  output  1  debounced level, registered.
- db_rise  output  1  one-cycle pulse, registered, coincident with the first cycle db_level=1.
- db_fall  output  1  one-cycle pulse, registered, coincident with the first cycle db_level=0.
- busy  output  1  registered; 1 while the FSM is in WAIT1 or WAIT0.

Behaviour:
- Clocking and reset:
  - Reset is asynchronous, active-high; clock is clk.
  - Reset forces state ZERO, counter 0 and synchronizer flops 0.
  - db_level, db_rise, db_fall and busy are all 0 immediately on reset.
  - Reset asserted mid-window abandons the window; no pulse is generated.
- Sample signal sw_s: the synchronized sw (see Optional Feature).
- FSM states: ZERO, WAIT1, ONE, WAIT0 (2-bit encoding).
- ZERO:
  - sw_s=1 -> WAIT1; load counter with STABLE_CNT-1.
  - Otherwise stay in ZERO.
- WAIT1:
  - sw_s=0 -> ZERO, with no pulse (glitch rejected).
  - sw_s=1 and counter=0 -> ONE; set db_rise for the next cycle.
  - sw_s=1 and counter/=0 -> decrement counter.
- ONE:
  - sw_s=0 -> WAIT0; load counter with STABLE_CNT-1.
  - Otherwise stay in ONE.
- WAIT0:
  - sw_s=1 -> ONE, with no pulse.
  - sw_s=0 and counter=0 -> ZERO; set db_fall for the next cycle.
  - Otherwise decrement counter.
- Outputs:
  - db_level is 1 in ONE and WAIT0, 0 in ZERO and WAIT1. It is registered from the next-state decode, so it changes in the same cycle the state changes.
  - db_rise and db_fall are each high for exactly one cycle per accepted transition and are never high together.
- Latency: if sw_s first reads 1 at cycle T and stays 1, db_level=1 and db_rise=1 at cycle T+STABLE_CNT+1. The falling direction is symmetric.
- Acceptance rule: any opposite sample inside a window restarts qualification from the stable state. The counter is reloaded on the next window entry.
- Counter: it never underflows, because the zero test precedes the decrement. The counter holds its value in ZERO and ONE.
- STABLE_CNT=1 is legal and gives a 2-sample qualification.

Optional Feature:
- Macro: DEBOUNCE_SYNC_EN.
- Defined: sw passes through a 2-flop synchronizer (reset value 0) before the FSM, so sw_s = sw delayed 2 cycles. Input-to-db_level latency is STABLE_CNT+3 cycles.
- Undefined: sw_s = sw directly. The caller guarantees sw is synchronous to clk. Latency is STABLE_CNT+1 cycles.

Test Plan:
All scenarios use STABLE_CNT=4 and CNT_W=3.
1. Reset held, then released with sw=0 for 20 cycles -> db_level=0, db_rise=0, db_fall=0, busy=0 throughout.
2. DEBOUNCE_SYNC_EN defined; sw 0->1 at cycle 0 and held -> busy=1 from cycle 3; db_level=1 and db_rise=1 at cycle 7; db_rise=0 at cycle 8; db_level stays 1.
3. Glitch: sw=1 for 3 cycles, then 0, from ZERO -> FSM returns to ZERO; db_level stays 0; no db_rise.
4. From ONE, sw bounces 0,1,0,1 at 1-cycle intervals, then holds 0 -> no db_fall during the bounce. A single db_fall occurs 5 sample cycles after the final 0 is sampled; db_level=0 from that cycle.
5. Reset pulsed while in WAIT1 with counter=2 -> all outputs 0 at once. After release with sw still 1, a full new 5-sample qualification is needed before db_rise.
6. DEBOUNCE_SYNC_EN undefined; sw 0->1 at cycle 0 -> db_rise at cycle 5; then sw->0 held -> db_fall exactly 5 cycles after the fall; db_rise and db_fall are never high in the same cycle.
